alu_arbiter: RTL and testbench

- Shares the single 8-bit combinational ALU among NUM_REQ requesters using round-robin arbitration.
- Accepts one operation at a time, drives the ALU operand and select lines from registered copies of the winner's request, and captures the result and zero flag.
- Returns the result to the winning requester through a valid/ready response handshake.
- Sits between the ALU and its clients: control unit, address-generation logic, and similar.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_rr.sv | 37 +++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU datapath widths (operand and select code)
//   - ALU select codes (op codes pass through the arbiter unmodified)
//   - Arbiter FSM state encoding
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int SEL_W = 3;

  // ALU select codes. 3'b001 is unnamed; the ALU treats it as add.
  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b010;
  localparam logic [SEL_W-1:0] OP_AND = 3'b011;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b100;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b101;
  localparam logic [SEL_W-1:0] OP_SHL = 3'b110;
  localparam logic [SEL_W-1:0] OP_SHR = 3'b111;

  // Arbiter FSM states.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recent winner
//   grant_oh   : one-hot winner (all zero when no request)
//   grant_idx  : binary index of the winner
//   grant_any  : at least one request is present
// Priority starts at last_grant+1 and wraps modulo N, so the most recent
// winner always has the lowest priority.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int k;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_grant) + i) % N;
      if (!grant_any && req[k]) begin
        grant_any   = 1'b1;
        grant_oh[k] = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit combinational ALU among NUM_REQ requesters.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   req_valid/req_ready  : per-requester request handshake
//   req_a, req_b, req_op : packed per-requester operands and select code
//   alu_in1/in2/sel      : registered drive to the ALU
//   alu_out, alu_z       : ALU result and zero flag
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_data, rsp_z      : captured result and zero flag
//   busy                 : FSM is not idle
//   state_dbg            : current FSM state for observation
//
// Handshakes: a request transfers in the IDLE cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is one-hot and only asserted in
// IDLE, and a requester holds req_valid and its operands until it sees
// req_ready. A response transfers on the edge where rsp_valid[g] and
// rsp_ready[g] are both high; rsp_valid, rsp_data and rsp_z hold until then.
// Flow: IDLE (accept) -> EXEC (capture ALU result) -> RESP (wait for ready).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] req_a,
  input  logic [NUM_REQ*ALU_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_op,
  output logic [ALU_W-1:0]         alu_in1,
  output logic [ALU_W-1:0]         alu_in2,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [ALU_W-1:0]         alu_out,
  input  logic                     alu_z,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [ALU_W-1:0]         rsp_data,
  output logic                     rsp_z,
  output logic                     busy,
  output logic [ST_W-1:0]          state_dbg
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [ALU_W-1:0] alu_in1_q, alu_in1_d;
  logic [ALU_W-1:0] alu_in2_q, alu_in2_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [ALU_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_z_q, rsp_z_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_sel_d    = alu_sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_z_d      = rsp_z_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready    = arb_oh;
          alu_in1_d    = req_a[arb_idx*ALU_W +: ALU_W];
          alu_in2_d    = req_b[arb_idx*ALU_W +: ALU_W];
          alu_sel_d    = req_op[arb_idx*SEL_W +: SEL_W];
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Operands have been stable for a full cycle; the ALU has settled.
        rsp_data_d = alu_out;
        rsp_z_d    = alu_z;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's ready matters.
        if (rsp_ready[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) rsp_valid[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_sel_q    <= '0;
      rsp_data_q   <= '0;
      rsp_z_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_sel_q    <= alu_sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with NUM_REQ=2. Contains a behavioural ALU
// connected to the DUT, a transaction-level reference model and a scoreboard.
module tb_alu_arbiter;

  localparam int N = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [7:0]     alu_in1, alu_in2, alu_out, rsp_data;
  logic [2:0]     alu_sel;
  logic           alu_z, rsp_z, busy;
  logic [1:0]     state_dbg;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_z     (rsp_z),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Behavioural ALU
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return a + b;
      3'b010:         return a - b;
      3'b011:         return a & b;
      3'b100:         return a | b;
      3'b101:         return a ^ b;
      3'b110:         return a << b[2:0];
      default:        return a >> b[2:0];
    endcase
  endfunction

  assign alu_out = alu_f(alu_in1, alu_in2, alu_sel);
  assign alu_z   = (alu_out == 8'd0);

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counters and scoreboard
  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {z, data} of the operation in flight
  int grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester-side stimulus state
  logic [N-1:0] pend;
  logic [7:0]   pa[N];
  logic [7:0]   pb[N];
  logic [2:0]   pop[N];
  logic [N-1:0] rdy_drv;
  int           mode;  // 0 directed, 1 all requesters re-arm, 2 random

  // Reference model: transaction-level view of the arbiter
  int         m_phase;  // 0 free, 1 computing, 2 waiting for response accept
  int         m_last;
  int         m_cur;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;

  // Values sampled during the most recent cycle
  logic [N-1:0] s_ready, s_rsp_valid;
  logic [7:0]   s_rsp_data;
  logic         s_rsp_z, s_hs;
  logic [2:0]   s_alu_sel;
  int           s_accept;

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pa[i]   = 8'($urandom_range(0, 255));
    pb[i]   = 8'($urandom_range(0, 255));
    pop[i]  = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*8 +: 8]    = pa[i];
      req_b[i*8 +: 8]    = pb[i];
      req_op[i*3 +: 3]   = pop[i];
    end
    rsp_ready = rdy_drv;
  endtask

  // One clock cycle: drive, sample and check at negedge, advance model, step.
  task automatic cycle();
    logic [N-1:0] exp_ready, exp_rv;
    int c;
    if (mode == 1) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      rdy_drv = N'($urandom_range(0, (1 << N) - 1));
    end
    drive_inputs();
    @(negedge clk);

    exp_ready = '0;
    s_accept  = -1;
    if (m_phase == 0 && pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (s_accept < 0 && pend[c]) s_accept = c;
      end
      exp_ready[s_accept] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    exp_rv = '0;
    if (m_phase == 2) exp_rv[m_cur] = 1'b1;
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, (m_phase != 0));
    if (m_phase != 0) begin
      check("alu_in1", alu_in1, m_a);
      check("alu_in2", alu_in2, m_b);
      check("alu_sel", alu_sel, m_op);
    end
    if (m_phase == 2) begin
      if (exp_q.size() > 0) begin
        check("rsp_data", rsp_data, exp_q[0][7:0]);
        check("rsp_z", rsp_z, exp_q[0][8]);
      end else begin
        check("sb_underflow", exp_q.size(), 1);
      end
    end

    s_ready     = req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    s_rsp_z     = rsp_z;
    s_alu_sel   = alu_sel;
    s_hs        = 1'b0;

    case (m_phase)
      0: if (s_accept >= 0) begin
        m_a  = pa[s_accept];
        m_b  = pb[s_accept];
        m_op = pop[s_accept];
        pend[s_accept] = 1'b0;
        m_last = s_accept;
        m_cur  = s_accept;
        exp_q.push_back({(alu_f(m_a, m_b, m_op) == 8'd0), alu_f(m_a, m_b, m_op)});
        grant_log.push_back(s_accept);
        m_phase = 1;
      end
      1: m_phase = 2;
      default: if (rdy_drv[m_cur]) begin
        s_hs = 1'b1;
        void'(exp_q.pop_front());
        m_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    pend    = '0;
    rdy_drv = '0;
    mode    = 0;
    m_phase = 0;
    m_last  = N - 1;
    m_cur   = 0;
    exp_q.delete();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      pa[i] = 8'd0; pb[i] = 8'd0; pop[i] = 3'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  int cnt;
  int n;
  int handshakes;

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    do_reset();

    // Single request: add 5+3
    rdy_drv = '1;
    set_req(0, 8'd5, 8'd3, 3'b000);
    cycle();
    check("single_ready", s_ready, 2'b01);
    cycle();
    check("single_no_rsp_exec", s_rsp_valid, 2'b00);
    cycle();
    check("single_rsp_valid", s_rsp_valid, 2'b01);
    check("single_data", s_rsp_data, 8'd8);
    check("single_z", s_rsp_z, 1'b0);

    // Zero flag from requester 1
    set_req(1, 8'h3C, 8'h3C, 3'b010);
    repeat (3) cycle();
    check("zero_rsp_valid", s_rsp_valid, 2'b10);
    check("zero_data", s_rsp_data, 8'h00);
    check("zero_z", s_rsp_z, 1'b1);

    // Shift passthrough
    set_req(0, 8'h81, 8'd1, 3'b110);
    cycle();
    cycle();
    check("shl_sel_exec", s_alu_sel, 3'b110);
    cycle();
    check("shl_data", s_rsp_data, 8'h02);
    check("shl_z", s_rsp_z, 1'b0);
    cycle();

    // Round-robin with both requesters continuously valid
    do_reset();
    mode = 1;
    rdy_drv = '1;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin
      cycle();
      n++;
    end
    if (grant_log.size() < 4) check("rr_timeout", grant_log.size(), 4);
    else for (int i = 0; i < 4; i++) check("rr_order", grant_log[i], i % 2);

    // Backpressure on requester 0 while requester 1 waits
    do_reset();
    set_req(0, 8'h12, 8'h34, 3'b101);
    set_req(1, 8'h55, 8'h0F, 3'b011);
    cycle();
    check("bp_first", s_accept, 0);
    cycle();
    cnt = 0;
    repeat (5) begin
      cycle();
      if (s_rsp_valid == 2'b01 && s_rsp_data == 8'h26) cnt++;
    end
    check("bp_hold", cnt, 5);
    rdy_drv = 2'b01;
    cycle();
    check("bp_handshake", s_hs, 1'b1);
    cycle();
    check("bp_next", s_accept, 1);
    rdy_drv = '1;
    repeat (3) cycle();

    // Reset during EXEC
    do_reset();
    set_req(0, 8'hA5, 8'h5A, 3'b100);
    cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_in1", alu_in1, 0);
    check("mid_rst_alu_in2", alu_in2, 0);
    check("mid_rst_alu_sel", alu_sel, 0);
    do_reset();
    set_req(0, 8'h01, 8'h02, 3'b000);
    set_req(1, 8'h03, 8'h04, 3'b000);
    rdy_drv = '1;
    cycle();
    check("mid_rst_first", s_accept, 0);
    repeat (8) cycle();

    // Randomized traffic with random response backpressure
    do_reset();
    mode = 2;
    handshakes = 0;
    repeat (600) begin
      cycle();
      if (s_hs) handshakes++;
    end
    mode = 0;
    rdy_drv = '1;
    repeat (12) cycle();
    check("rand_activity", (handshakes > 50), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
